decoder_scan_ctrl: RTL



---
 rtl/decoder_scan_ctrl.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/decoder_scan_ctrl.sv
// Scan sequencer for a 3-to-8 decoder: sweeps masked channels with a
// programmable dwell and a one-cycle blank between channels.
module decoder_scan_ctrl #(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic               mode,
  input  logic [7:0]         mask,
  input  logic [DWELL_W-1:0] dwell,
  output logic [2:0]         A,
  output logic               E,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    BLANK = 2'd2
  } state_e;

  localparam logic [DWELL_W-1:0] ONE = {{(DWELL_W-1){1'b0}}, 1'b1};

  state_e             state_q, state_d;
  logic [2:0]         a_q, a_d;
  logic               e_q, e_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               mode_q, mode_d;
  logic [7:0]         mask_q, mask_d;
  logic [DWELL_W-1:0] n_q, n_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;

  logic [DWELL_W-1:0] dwell_n;
  logic [7:0]         above;

  function automatic logic [2:0] lowest(input logic [7:0] m);
    logic [2:0] lo;
    lo = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i]) lo = 3'(i);
    end
    return lo;
  endfunction

  assign dwell_n = (dwell == '0) ? ONE : dwell;
  // Shadow-mask channels strictly above the current pointer
  assign above   = mask_q & (8'hFE << a_q);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    e_d     = e_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    mode_d  = mode_q;
    mask_d  = mask_q;
    n_d     = n_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start && !stop) begin
          if (mask != 8'h00) begin
            mode_d  = mode;
            mask_d  = mask;
            n_d     = dwell_n;
            cnt_d   = dwell_n;
            a_d     = lowest(mask);
            e_d     = 1'b1;
            busy_d  = 1'b1;
            state_d = DRIVE;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      DRIVE: begin
        if (stop) begin
          e_d     = 1'b0;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else if (cnt_q == ONE) begin
          e_d     = 1'b0;
          state_d = BLANK;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      BLANK: begin
        if (stop) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end else if (above != 8'h00) begin
          a_d     = lowest(above);
          e_d     = 1'b1;
          cnt_d   = n_q;
          state_d = DRIVE;
        end else if (mode_q) begin
          a_d     = lowest(mask_q);
          e_d     = 1'b1;
          cnt_d   = n_q;
          state_d = DRIVE;
        end else begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        e_d     = 1'b0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= 3'd0;
      e_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      mode_q  <= 1'b0;
      mask_q  <= 8'h00;
      n_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      e_q     <= e_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      mode_q  <= mode_d;
      mask_q  <= mask_d;
      n_q     <= n_d;
      cnt_q   <= cnt_d;
    end
  end

  assign A    = a_q;
  assign E    = e_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule
